// File: rtl/branch_predict_npc.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_npc
// Purpose  : Next-PC generator: direct-mapped BTB with 2-bit direction
//            counters, EX redirect override and one-branch-per-cycle update.
//            Define BPRED_STATS_EN to add lookup/redirect statistics ports.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predict_npc #(
   parameter int ENTRIES = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] pc_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        mem_stall_i,
   input  logic        upd_valid_i,
   input  logic [31:0] upd_pc_i,
   input  logic        upd_taken_i,
   input  logic [31:0] upd_target_i,
`ifdef BPRED_STATS_EN
   output logic [31:0] lookup_cnt_o,
   output logic [31:0] redirect_cnt_o,
`endif
   output logic [31:0] next_pc_o,
   output logic        pred_taken_o
);

   localparam int IDX  = $clog2(ENTRIES);
   localparam int TAGW = 30 - IDX;

   logic            r_valid  [ENTRIES];
   logic [TAGW-1:0] r_tag    [ENTRIES];
   logic [29:0]     r_target [ENTRIES];
   logic [1:0]      r_ctr    [ENTRIES];

   logic [IDX-1:0]  w_lk_idx;
   logic [TAGW-1:0] w_lk_tag;
   logic            w_lk_hit;
   logic            w_pred;
   logic [IDX-1:0]  w_up_idx;
   logic [TAGW-1:0] w_up_tag;
   logic            w_up_hit;
   logic            w_up_en;
   logic            w_unused;

   assign w_unused = ^{pc_i[1:0], upd_pc_i[1:0], upd_target_i[1:0]};

   // Lookup reads the stored state only, so a same-cycle update is not seen
   assign w_lk_idx = pc_i[IDX+1:2];
   assign w_lk_tag = pc_i[31:IDX+2];
   assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
   assign w_pred   = w_lk_hit && r_ctr[w_lk_idx][1] && !rst_i && !redirect_i;

   assign pred_taken_o = w_pred;

   always_comb begin
      next_pc_o = pc_i + 32'd4;
      if (rst_i) begin
         next_pc_o = 32'd0;
      end else if (redirect_i) begin
         next_pc_o = redirect_pc_i;
      end else if (w_pred) begin
         next_pc_o = {r_target[w_lk_idx], 2'b00};
      end
   end

   assign w_up_idx = upd_pc_i[IDX+1:2];
   assign w_up_tag = upd_pc_i[31:IDX+2];
   assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
   assign w_up_en  = upd_valid_i && !mem_stall_i && !rst_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i] <= 1'b0;
            r_ctr[i]   <= 2'b01;
         end
      end else if (w_up_en) begin
         if (w_up_hit) begin
            if (upd_taken_i && (r_ctr[w_up_idx] != 2'b11)) begin
               r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 2'b01;
            end else if (!upd_taken_i && (r_ctr[w_up_idx] != 2'b00)) begin
               r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 2'b01;
            end
         end else if (upd_taken_i) begin
            r_valid[w_up_idx] <= 1'b1;
            r_ctr[w_up_idx]   <= 2'b10;
         end
      end
   end

   // Tag/target carry no reset; a taken update writes them on hit or allocate
   always_ff @(posedge clk_i) begin
      if (w_up_en && upd_taken_i) begin
         r_tag[w_up_idx]    <= w_up_tag;
         r_target[w_up_idx] <= upd_target_i[31:2];
      end
   end

`ifdef BPRED_STATS_EN
   logic [31:0] r_lookup_cnt;
   logic [31:0] r_redirect_cnt;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_lookup_cnt   <= 32'd0;
         r_redirect_cnt <= 32'd0;
      end else begin
         if (!mem_stall_i) begin
            r_lookup_cnt <= r_lookup_cnt + 32'd1;
         end
         if (redirect_i) begin
            r_redirect_cnt <= r_redirect_cnt + 32'd1;
         end
      end
   end

   assign lookup_cnt_o   = r_lookup_cnt;
   assign redirect_cnt_o = r_redirect_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_npc.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predict_npc
// Purpose  : Self-checking bench for branch_predict_npc against a table model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predict_npc;

   localparam int ENTRIES = 16;
   localparam int IDX     = 4;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] pc_i = '0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        mem_stall_i = 1'b0;
   logic        upd_valid_i = 1'b0;
   logic [31:0] upd_pc_i = '0;
   logic        upd_taken_i = 1'b0;
   logic [31:0] upd_target_i = '0;
   logic [31:0] next_pc_o;
   logic        pred_taken_o;
`ifdef BPRED_STATS_EN
   logic [31:0] lookup_cnt_o;
   logic [31:0] redirect_cnt_o;
`endif

   int tests  = 0;
   int failed = 0;

   branch_predict_npc #(.ENTRIES(ENTRIES)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .pc_i          (pc_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .mem_stall_i   (mem_stall_i),
      .upd_valid_i   (upd_valid_i),
      .upd_pc_i      (upd_pc_i),
      .upd_taken_i   (upd_taken_i),
      .upd_target_i  (upd_target_i),
`ifdef BPRED_STATS_EN
      .lookup_cnt_o  (lookup_cnt_o),
      .redirect_cnt_o(redirect_cnt_o),
`endif
      .next_pc_o     (next_pc_o),
      .pred_taken_o  (pred_taken_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference table: remembers the full PC of the branch that owns each slot
   bit          m_valid [ENTRIES];
   logic [31:0] m_owner [ENTRIES];
   logic [31:0] m_tgt   [ENTRIES];
   int          m_ctr   [ENTRIES];

   function automatic int slot_of(logic [31:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   function automatic bit m_hit(logic [31:0] pc);
      int s = slot_of(pc);
      return m_valid[s] && ((m_owner[s] >> (IDX + 2)) == (pc >> (IDX + 2)));
   endfunction

   function automatic bit m_pred();
      return !rst_i && !redirect_i && m_hit(pc_i) && (m_ctr[slot_of(pc_i)] >= 2);
   endfunction

   function automatic logic [31:0] m_next();
      if (rst_i)      return 32'd0;
      if (redirect_i) return redirect_pc_i;
      if (m_pred())   return m_tgt[slot_of(pc_i)];
      return pc_i + 32'd4;
   endfunction

   task automatic model_edge();
      int s;
      if (rst_i) begin
         for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
         end
      end else if (upd_valid_i && !mem_stall_i) begin
         s = slot_of(upd_pc_i);
         if (m_hit(upd_pc_i)) begin
            if (upd_taken_i) begin
               m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
               m_tgt[s] = upd_target_i & 32'hFFFF_FFFC;
            end else begin
               m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
            end
         end else if (upd_taken_i) begin
            m_valid[s] = 1'b1;
            m_owner[s] = upd_pc_i;
            m_tgt[s]   = upd_target_i & 32'hFFFF_FFFC;
            m_ctr[s]   = 2;
         end
      end
   endtask

   // Advance one clock: model follows the DUT edge, inputs change at negedge
   task automatic tick();
      @(posedge clk_i);
      model_edge();
      @(negedge clk_i);
   endtask

   task automatic set_upd(input logic v, input logic [31:0] pc, input logic t,
                          input logic [31:0] tgt);
      upd_valid_i  = v;
      upd_pc_i     = pc;
      upd_taken_i  = t;
      upd_target_i = tgt;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      pc_i  = 32'h0000_0040;
      tick();
      #1;
      tests++;
      if (next_pc_o !== 32'd0 || pred_taken_o !== 1'b0) begin
         failed++;
         $display("FAIL reset: next_pc=%h pred=%b, want 00000000/0", next_pc_o, pred_taken_o);
      end
      rst_i = 1'b0;
   endtask

   task automatic test_fallthrough();
      pc_i = 32'h0000_0100;
      #1;
      tests++;
      if (next_pc_o !== 32'h0000_0104 || pred_taken_o !== 1'b0) begin
         failed++;
         $display("FAIL fallthrough: next_pc=%h pred=%b, want 00000104/0", next_pc_o, pred_taken_o);
      end
      pc_i = 32'hFFFF_FFFC;
      #1;
      tests++;
      if (next_pc_o !== 32'h0000_0000) begin
         failed++;
         $display("FAIL wrap: next_pc=%h, want 00000000", next_pc_o);
      end
      tick();
   endtask

   task automatic test_allocate();
      set_upd(1'b1, 32'h40, 1'b1, 32'h80);
      pc_i = 32'h40;
      #1;
      tests++;
      if (next_pc_o !== 32'h44 || pred_taken_o !== 1'b0) begin
         failed++;
         $display("FAIL same_cycle_update: next_pc=%h pred=%b, want 00000044/0", next_pc_o, pred_taken_o);
      end
      tick();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      tests++;
      if (next_pc_o !== 32'h80 || pred_taken_o !== 1'b1) begin
         failed++;
         $display("FAIL allocate: next_pc=%h pred=%b, want 00000080/1", next_pc_o, pred_taken_o);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 3; i++) begin
         set_upd(1'b1, 32'h40, 1'b1, 32'h80);
         tick();
      end
      set_upd(1'b1, 32'h40, 1'b0, 32'h0);
      tick();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      tests++;
      if (next_pc_o !== 32'h80 || pred_taken_o !== 1'b1) begin
         failed++;
         $display("FAIL sat_one_nt: next_pc=%h pred=%b, want 00000080/1", next_pc_o, pred_taken_o);
      end
      set_upd(1'b1, 32'h40, 1'b0, 32'h0);
      tick();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      tests++;
      if (next_pc_o !== 32'h44 || pred_taken_o !== 1'b0) begin
         failed++;
         $display("FAIL sat_two_nt: next_pc=%h pred=%b, want 00000044/0", next_pc_o, pred_taken_o);
      end
   endtask

   task automatic test_alias();
      set_upd(1'b1, 32'h440, 1'b1, 32'h300);
      tick();
      set_upd(1'b1, 32'h88, 1'b0, 32'h500);
      pc_i = 32'h40;
      #1;
      tests++;
      if (next_pc_o !== 32'h44 || pred_taken_o !== 1'b0) begin
         failed++;
         $display("FAIL alias_evict: next_pc=%h pred=%b, want 00000044/0", next_pc_o, pred_taken_o);
      end
      pc_i = 32'h440;
      #1;
      tests++;
      if (next_pc_o !== 32'h300 || pred_taken_o !== 1'b1) begin
         failed++;
         $display("FAIL alias_new: next_pc=%h pred=%b, want 00000300/1", next_pc_o, pred_taken_o);
      end
      tick();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      pc_i = 32'h88;
      #1;
      tests++;
      if (next_pc_o !== 32'h8C || pred_taken_o !== 1'b0) begin
         failed++;
         $display("FAIL nt_no_alloc: next_pc=%h pred=%b, want 0000008c/0", next_pc_o, pred_taken_o);
      end
   endtask

   task automatic test_redirect();
      pc_i          = 32'h440;
      redirect_i    = 1'b1;
      redirect_pc_i = 32'h200;
      set_upd(1'b1, 32'h104, 1'b1, 32'h600);
      #1;
      tests++;
      if (next_pc_o !== 32'h200 || pred_taken_o !== 1'b0) begin
         failed++;
         $display("FAIL redirect: next_pc=%h pred=%b, want 00000200/0", next_pc_o, pred_taken_o);
      end
      tick();
      redirect_i = 1'b0;
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      pc_i = 32'h104;
      #1;
      tests++;
      if (next_pc_o !== 32'h600 || pred_taken_o !== 1'b1) begin
         failed++;
         $display("FAIL redirect_update: next_pc=%h pred=%b, want 00000600/1", next_pc_o, pred_taken_o);
      end
   endtask

   task automatic test_stall();
      // Strengthen 0x104 to strong-taken, then hold a not-taken update across a stall
      set_upd(1'b1, 32'h104, 1'b1, 32'h600);
      tick();
      set_upd(1'b1, 32'h104, 1'b0, 32'h0);
      pc_i = 32'h104;
      for (int i = 0; i < 4; i++) begin
         mem_stall_i = (i < 3);
         tick();
      end
      mem_stall_i = 1'b0;
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      tests++;
      if (next_pc_o !== 32'h600 || pred_taken_o !== 1'b1) begin
         failed++;
         $display("FAIL stall_one_step: next_pc=%h pred=%b, want 00000600/1", next_pc_o, pred_taken_o);
      end
      set_upd(1'b1, 32'h104, 1'b0, 32'h0);
      tick();
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      tests++;
      if (next_pc_o !== 32'h108 || pred_taken_o !== 1'b0) begin
         failed++;
         $display("FAIL stall_followup: next_pc=%h pred=%b, want 00000108/0", next_pc_o, pred_taken_o);
      end
   endtask

   task automatic test_reset_midway();
      set_upd(1'b1, 32'h440, 1'b1, 32'h300);
      tick();
      rst_i = 1'b1;
      set_upd(1'b1, 32'h1C0, 1'b1, 32'h20);
      pc_i = 32'h440;
      tick();
      rst_i = 1'b0;
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      tests++;
      if (next_pc_o !== 32'h444 || pred_taken_o !== 1'b0) begin
         failed++;
         $display("FAIL reset_clears: next_pc=%h pred=%b, want 00000444/0", next_pc_o, pred_taken_o);
      end
      pc_i = 32'h1C0;
      #1;
      tests++;
      if (next_pc_o !== 32'h1C4 || pred_taken_o !== 1'b0) begin
         failed++;
         $display("FAIL reset_drops_update: next_pc=%h pred=%b, want 000001c4/0", next_pc_o, pred_taken_o);
      end
   endtask

   task automatic test_random();
      logic [31:0] pool [8];
      logic [31:0] exp_pc;
      bit          exp_pred;
      pool = '{32'h40, 32'h440, 32'h104, 32'h88, 32'h1000, 32'hFFFF_FFFC, 32'h3C, 32'h43C};
      for (int n = 0; n < 400; n++) begin
         rst_i         = ($urandom_range(0, 63) == 0);
         redirect_i    = ($urandom_range(0, 7) == 0);
         redirect_pc_i = $urandom & 32'hFFFF_FFFC;
         mem_stall_i   = ($urandom_range(0, 3) == 0);
         pc_i          = pool[$urandom_range(0, 7)];
         set_upd($urandom_range(0, 1) == 1, pool[$urandom_range(0, 7)],
                 $urandom_range(0, 2) != 0, $urandom);
         #1;
         exp_pc   = m_next();
         exp_pred = m_pred();
         tests++;
         if (next_pc_o !== exp_pc || pred_taken_o !== exp_pred) begin
            failed++;
            $display("FAIL random[%0d] pc=%h: next_pc=%h pred=%b, want %h/%b",
                     n, pc_i, next_pc_o, pred_taken_o, exp_pc, exp_pred);
         end
         tick();
      end
      rst_i = 1'b0;
      redirect_i = 1'b0;
      mem_stall_i = 1'b0;
      set_upd(1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   initial begin
      @(negedge clk_i);
      test_reset();
      test_fallthrough();
      test_allocate();
      test_saturation();
      test_alias();
      test_redirect();
      test_stall();
      test_reset_midway();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/branch_predict_npc.md
# branch_predict_npc

- Next-PC generator that sits directly upstream of the program counter register and drives its `pc_i`.
- Looks up the current fetch PC in a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters.
- Outputs either the predicted taken target or PC+4; a resolved-branch redirect from EX overrides both.
- EX-stage resolution updates the table one branch at a time.

## Interface

- `ENTRIES`, 16: BTB entries; power of two, 4..256. `IDX = log2(ENTRIES)`.
- `clk_i` input 1: clock; all state updates on its rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `pc_i` input 32: current fetch PC, the PC register output; bits [1:0] ignored.
- `redirect_i` input 1: EX found a misprediction; redirect fetch.
- `redirect_pc_i` input 32: correct next PC when `redirect_i`=1.
- `mem_stall_i` input 1: data-memory stall; table updates are suppressed while high.
- `upd_valid_i` input 1: one resolved branch/jump is presented this cycle.
- `upd_pc_i` input 32: PC of the resolved instruction.
- `upd_taken_i` input 1: actual direction.
- `upd_target_i` input 32: actual taken target.
- `next_pc_o` output 32: value for the PC register's `pc_i`.
- `pred_taken_o` output 1: prediction for the instruction at `pc_i`; carried down the pipeline to EX.
- `lookup_cnt_o` output 32: present only with `BPRED_STATS_EN`.
- `redirect_cnt_o` output 32: present only with `BPRED_STATS_EN`.

## Operation

Entry fields: `valid`, `tag[31-IDX-2:0]`, `target[31:2]`, `ctr[1:0]`.
- Index is `pc[IDX+1:2]`; tag is `pc[31:IDX+2]`.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.

Lookup (combinational):
- hit = `valid` && tag match.
- `pred_taken_o` = hit && `ctr[1]`.
- `next_pc_o` priority:
  - `rst_i`=1 → 0.
  - else `redirect_i`=1 → `redirect_pc_i`.
  - else `pred_taken_o`=1 → {`target`, 2'b00}.
  - else `pc_i` + 4, modulo 2^32 (0xFFFFFFFC → 0x00000000).
- `pred_taken_o` is forced to 0 when `rst_i` or `redirect_i` is high.

Update: performed when `upd_valid_i` && !`mem_stall_i` && !`rst_i`.
- Hit, taken: `ctr` saturating +1; `target` ← `upd_target_i[31:2]`.
- Hit, not taken: `ctr` saturating −1; `target` unchanged.
- Miss, taken: allocate by overwriting the slot. Set `valid`=1, write tag and target, `ctr`=10.
- Miss, not taken: no change.

Reset (synchronous): all `valid` ← 0, all `ctr` ← 01, tags/targets don't-care, stats counters ← 0.

## Timing

- Lookup has zero latency: `next_pc_o` and `pred_taken_o` are pure combinational functions of `pc_i`, `redirect_*` and the stored table state.
- An update sampled at edge N is visible to lookups only after edge N. If the lookup index equals the update index in the same cycle, the lookup uses the pre-update entry.
- `upd_valid_i` is level-sampled each unstalled cycle. EX presents each resolved branch for exactly one unstalled cycle.
  - Holding `upd_valid_i` through a `mem_stall_i` window yields exactly one update: the first cycle with `mem_stall_i`=0.
- `redirect_i` is not gated by `mem_stall_i`. The PC register drops the value itself while stalled, so EX holds `redirect_i` until the stall clears.
- `redirect_i` and `upd_valid_i` in the same cycle are independent: the redirect applies to `next_pc_o` and the update is written.
- `rst_i` asserted mid-operation: the table is cleared at the next edge; any same-cycle update is discarded.
- Output values at reset, while `rst_i`=1: `next_pc_o`=0, `pred_taken_o`=0, stats outputs=0.

## Configuration

- `BPRED_STATS_EN` defined:
  - Adds `lookup_cnt_o`, which increments on every edge with `rst_i`=0 and `mem_stall_i`=0.
  - Adds `redirect_cnt_o`, which increments on every edge with `rst_i`=0 and `redirect_i`=1.
  - Both are 32-bit and wrap 0xFFFFFFFF → 0.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

## Test plan

- Reset, then `pc_i`=0x00000100 with no updates → `next_pc_o`=0x00000104, `pred_taken_o`=0. Repeat with `pc_i`=0xFFFFFFFC → `next_pc_o`=0x00000000.
- Update `upd_pc_i`=0x40, taken, target 0x80 → on the next cycle, `pc_i`=0x40 gives `next_pc_o`=0x80, `pred_taken_o`=1. In the same cycle as that update, a lookup at 0x40 still gives 0x44.
- Counter saturation:
  - Starting from the entry above, apply 3 taken updates → `ctr`=11.
  - Then 1 not-taken update → still predicts 0x80.
  - A second not-taken update → predicts 0x44.
- Alias and miss cases (ENTRIES=16):
  - Taken update at 0x440 evicts 0x40; lookup at 0x40 → 0x44.
  - A not-taken update at a miss address does not allocate.
- `redirect_i`=1 with `redirect_pc_i`=0x200 while `pc_i` hits a taken entry → `next_pc_o`=0x200, `pred_taken_o`=0. Same-cycle update is still written.
- `upd_valid_i` held 4 cycles, `mem_stall_i` high for the first 3 → exactly one counter step. Assert `rst_i` with an update pending → after the edge the lookup misses and the update is lost.
